tick_timer: RTL and testbench
=============================

// Module: tick_timer
// PURPOSE
//  Programmable down-counting timer driven by the 1-cycle tick strobe of the
//  upstream pulse counter (one tick every 5 clk). Counts a loaded number of
//  ticks, then flags expiry with a 1-cycle pulse and a sticky irq. Supports
//  one-shot and periodic (auto-reload) modes. Detects expiries missed by
//  software (overrun).
// PARAMETERS
//  WIDTH  8  width of load value and tick count
// PORTS
//  clk       in   1      rising-edge clock, single clock domain
//  reset     in   1      synchronous, active-high reset
//  tick_in   in   1      tick strobe from the upstream counter (out_pulse)
//  start     in   1      1-cycle request: load load_val and run
//  stop      in   1      1-cycle request: abort and return to IDLE
//  periodic  in   1      1 = auto-reload on expiry, 0 = one-shot; sampled at start
//  load_val  in   WIDTH  tick count to expire after; sampled at start
//  irq_clr   in   1      clears irq and overrun
//  busy      out  1      1 while in RUN
//  count     out  WIDTH  remaining ticks
//  expired   out  1      1-cycle pulse on expiry
//  irq       out  1      sticky expiry flag
//  overrun   out  1      sticky: expiry occurred while irq still set
// BEHAVIOUR
//  - All outputs registered. Reset (sync, high) forces state=IDLE, count=0,
//    busy=0, expired=0, irq=0, overrun=0. Reset overrides every other input.
//  - FSM states: IDLE, RUN. busy = (state==RUN).
//  - Priority each cycle: reset > stop > start > tick_in.
//  - IDLE: start & load_val!=0 -> count<=load_val, reload<=load_val,
//    mode<=periodic, go RUN. start with load_val==0 is ignored.
//    tick_in is ignored in IDLE.
//  - RUN:
//    - stop -> IDLE, count<=0, no expiry, even if a tick is present.
//    - start (no stop) -> restart: reload and count<=load_val, mode<=periodic.
//      load_val==0 -> IDLE, count<=0.
//    - tick_in & count>1 -> count<=count-1.
//    - tick_in & count==1 -> expiry. Periodic: count<=reload, stay in RUN.
//      One-shot: count<=0, go IDLE.
//    - no tick -> hold.
//  - Expiry latency: tick on cycle n with count==1 -> expired=1 on cycle n+1
//    only. busy falls on n+1 (one-shot). irq rises on n+1.
//  - irq_next     = expiry | (irq & ~irq_clr). Expiry wins over a simultaneous clr.
//  - overrun_next = (expiry & irq & ~irq_clr) | (overrun & ~irq_clr).
//  - Arithmetic is unsigned WIDTH-bit. count never wraps below 0.
//    load_val = 2^WIDTH-1 is legal.
//  - Periodic with reload==1: expires on every tick, with no idle gap.
//  - Mid-operation reset: immediate IDLE, all flags cleared, no expired pulse.
// TESTING
//  1 Reset: hold reset 2 cycles with start=1 -> busy=0, count=0, irq=0,
//    expired=0 throughout.
//  2 One-shot: load_val=3, periodic=0, start; ticks every 5 clk -> count
//    3,2,1,0. expired pulses once, the cycle after the 3rd tick. irq=1.
//    busy=0 afterwards.
//  3 Periodic: load_val=2, periodic=1 -> expired after ticks 2,4,6. count
//    reloads to 2. busy stays 1. Without irq_clr, overrun=1 after the 2nd
//    expiry.
//  4 Priority: stop together with the final tick (count==1) -> no expired
//    pulse, IDLE, count=0. start in RUN with load_val=7 -> count=7 next cycle.
//  5 irq_clr on the same cycle as an expiry -> irq stays 1, overrun stays 0.
//    irq_clr alone -> irq=0, overrun=0.
//  6 Edges: start with load_val=0 -> stays IDLE. load_val=255 counts the
//    full 255 ticks. reset mid-run at count=4 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - programmable tick-driven down-counting timer with sticky irq/overrun
//
// Counts a loaded number of upstream tick strobes, then pulses expired for one
// cycle and sets a sticky irq. One-shot mode returns to IDLE on expiry; periodic
// mode reloads and keeps running. An expiry that lands while irq is still set
// (and not being cleared) raises the sticky overrun flag.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   tick_in   1-cycle tick strobe from the upstream pulse counter
//   start     1-cycle request: load load_val, latch periodic, run
//   stop      1-cycle request: abort and return to IDLE
//   periodic  1 = auto-reload on expiry, 0 = one-shot (sampled at start)
//   load_val  tick count to expire after (sampled at start, 0 = no-op/abort)
//   irq_clr   clears irq and overrun (a simultaneous expiry still sets irq)
//   busy      1 while running
//   count     remaining ticks
//   expired   1-cycle expiry pulse
//   irq       sticky expiry flag
//   overrun   sticky flag: expiry while irq still pending
module tick_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick_in,
   input  logic             start,
   input  logic             stop,
   input  logic             periodic,
   input  logic [WIDTH-1:0] load_val,
   input  logic             irq_clr,
   output logic             busy,
   output logic [WIDTH-1:0] count,
   output logic             expired,
   output logic             irq,
   output logic             overrun
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] count_nxt;
   logic [WIDTH-1:0] reload, reload_nxt;
   logic             mode, mode_nxt;
   logic             expiry;
   logic             irq_nxt;
   logic             overrun_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         count   <= '0;
         reload  <= '0;
         mode    <= 1'b0;
         expired <= 1'b0;
         irq     <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state   <= state_nxt;
         count   <= count_nxt;
         reload  <= reload_nxt;
         mode    <= mode_nxt;
         expired <= expiry;
         irq     <= irq_nxt;
         overrun <= overrun_nxt;
      end
   end

   // busy is decoded straight from the state register, so it stays registered.
   assign busy = (state == RUN);

   always_comb begin
      state_nxt  = state;
      count_nxt  = count;
      reload_nxt = reload;
      mode_nxt   = mode;
      expiry     = 1'b0;

      case (state)
         IDLE: begin
            // stop outranks start, so a simultaneous stop blocks the launch.
            // Ticks are ignored while idle.
            if (!stop && start && (load_val != '0)) begin
               state_nxt  = RUN;
               count_nxt  = load_val;
               reload_nxt = load_val;
               mode_nxt   = periodic;
            end
         end
         RUN: begin
            if (stop) begin
               state_nxt = IDLE;
               count_nxt = '0;
            end else if (start) begin
               if (load_val != '0) begin
                  count_nxt  = load_val;
                  reload_nxt = load_val;
                  mode_nxt   = periodic;
               end else begin
                  state_nxt = IDLE;
                  count_nxt = '0;
               end
            end else if (tick_in) begin
               if (count > WIDTH'(1)) begin
                  count_nxt = count - WIDTH'(1);
               end else if (count == WIDTH'(1)) begin
                  expiry = 1'b1;
                  if (mode) begin
                     count_nxt = reload;
                  end else begin
                     state_nxt = IDLE;
                     count_nxt = '0;
                  end
               end
               // count==0 cannot occur in RUN; holding keeps it from wrapping.
            end
         end
         default: begin
            state_nxt = IDLE;
            count_nxt = '0;
         end
      endcase

      // A fresh expiry wins over a same-cycle clear; overrun looks at the irq
      // that was still pending before this expiry.
      irq_nxt     = expiry | (irq & ~irq_clr);
      overrun_nxt = (expiry & irq & ~irq_clr) | (overrun & ~irq_clr);
   end

endmodule

// File: tb/tb_tick_timer.sv
// tb/tb_tick_timer.sv - scoreboard bench for tick_timer with a behavioural reference model
module tb_tick_timer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       tick_in = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       periodic = 1'b0;
   logic [7:0] load_val = 8'd0;
   logic       irq_clr = 1'b0;
   logic       busy;
   logic [7:0] count;
   logic       expired;
   logic       irq;
   logic       overrun;

   tick_timer #(.WIDTH(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .tick_in  (tick_in),
      .start    (start),
      .stop     (stop),
      .periodic (periodic),
      .load_val (load_val),
      .irq_clr  (irq_clr),
      .busy     (busy),
      .count    (count),
      .expired  (expired),
      .irq      (irq),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit busy;
      int cnt;
      bit exp;
      bit irq;
      bit ovr;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;

   // Reference model state: plain integers and flags.
   bit m_run = 0;
   int m_cnt = 0;
   int m_reload = 0;
   bit m_per = 0;
   bit m_irq = 0;
   bit m_ovr = 0;
   bit m_exp = 0;
   int tph = 0;

   // One clock of stimulus: drive inputs away from the edge, advance the model
   // to the state the DUT should show after the coming rising edge, and queue it.
   task automatic cyc(input bit rst, input bit st, input bit sp, input bit per,
                      input int lv, input bit clr, input bit tk);
      bit   fire;
      exp_t x;
      @(negedge clk);
      reset    = rst;
      start    = st;
      stop     = sp;
      periodic = per;
      load_val = lv[7:0];
      irq_clr  = clr;
      tick_in  = tk;
      fire = 0;
      if (rst) begin
         m_run = 0; m_cnt = 0; m_reload = 0; m_per = 0;
         m_irq = 0; m_ovr = 0; m_exp = 0;
      end else begin
         if (sp) begin
            m_run = 0;
            m_cnt = 0;
         end else if (st) begin
            if (lv != 0) begin
               m_run = 1; m_cnt = lv; m_reload = lv; m_per = per;
            end else begin
               m_run = 0; m_cnt = 0;
            end
         end else if (m_run && tk) begin
            if (m_cnt > 1) m_cnt = m_cnt - 1;
            else begin
               fire = 1;
               if (m_per) m_cnt = m_reload;
               else begin
                  m_run = 0; m_cnt = 0;
               end
            end
         end
         m_ovr = (fire && m_irq && !clr) || (m_ovr && !clr);
         m_irq = fire || (m_irq && !clr);
         m_exp = fire;
      end
      x.busy = m_run; x.cnt = m_cnt; x.exp = m_exp; x.irq = m_irq; x.ovr = m_ovr;
      q.push_back(x);
   endtask

   // n quiet cycles with the upstream tick every 5 clocks.
   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(0, 0, 0, 0, 0, 0, tph == 4);
         tph = (tph + 1) % 5;
      end
   endtask

   // Monitor: the DUT presents a fresh output set after each rising edge.
   always begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if (busy !== e.busy || count !== e.cnt[7:0] || expired !== e.exp ||
             irq !== e.irq || overrun !== e.ovr) begin
            errors++;
            $display("FAIL outputs @%0t: got busy=%0b count=%0d expired=%0b irq=%0b overrun=%0b, required busy=%0b count=%0d expired=%0b irq=%0b overrun=%0b",
                     $time, busy, count, expired, irq, overrun,
                     e.busy, e.cnt, e.exp, e.irq, e.ovr);
         end
      end
   end

   initial begin
      int lv;
      // 1 reset held with start asserted
      cyc(1, 1, 0, 0, 5, 0, 1);
      cyc(1, 1, 0, 1, 5, 0, 1);
      run_ticks(3);
      // 2 one-shot of 3 ticks
      cyc(0, 1, 0, 0, 3, 0, 0);
      tph = 0;
      run_ticks(20);
      // 3 periodic of 2 ticks, no clear -> overrun
      cyc(0, 1, 0, 1, 2, 0, 0);
      tph = 0;
      run_ticks(33);
      cyc(0, 0, 1, 0, 0, 1, 0);
      // 4 stop with the final tick, then restart in RUN
      cyc(0, 1, 0, 0, 2, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 1, 0, 0, 0, 1);
      cyc(0, 1, 0, 0, 5, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 1, 0, 0, 7, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0, 0);
      // 5 irq_clr coincident with an expiry, then alone
      cyc(0, 1, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 1, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0);
      // periodic reload==1: back-to-back expiries
      cyc(0, 1, 0, 1, 1, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 1, 0, 0, 1, 0);
      // 6 edges: load 0 ignored, full-scale count, reset mid-run
      cyc(0, 1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 1, 0, 0, 255, 0, 0);
      tph = 0;
      run_ticks(255 * 5 + 3);
      cyc(0, 1, 0, 1, 6, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         lv = ($urandom_range(0, 15) == 0) ? 255 : int'($urandom_range(0, 6));
         cyc($urandom_range(0, 299) == 0,
             $urandom_range(0, 29) == 0,
             $urandom_range(0, 79) == 0,
             $urandom_range(0, 1) == 1,
             lv,
             $urandom_range(0, 19) == 0,
             (tph == 4) || ($urandom_range(0, 9) == 0));
         tph = (tph + 1) % 5;
      end
      @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expectations, required 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
